// File: rtl/ecall_halt_controller_pkg.sv
// Shared CPU definitions for the ecall halt path: FSM states, x17 defaults
// and the x17 operand-mux select encodings.
package ecall_halt_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [4:0]  ECALL_REG_DEFAULT = 5'd17;
    localparam logic [31:0] HALT_CODE_DEFAULT = 32'd10;

    localparam logic [1:0] FWD_RF     = 2'd0;
    localparam logic [1:0] FWD_EX_MEM = 2'd1;
    localparam logic [1:0] FWD_MEM_WB = 2'd2;

    // x0 is hardwired, so a write to it can never supply the ecall operand
    function automatic logic rd_hits(input logic [4:0] rd, input logic [4:0] target);
        return (rd != 5'd0) && (rd == target);
    endfunction

endpackage

// File: rtl/ecall_x17_hazard.sv
// x17 operand forwarding select and load-use/ALU-in-EX hazard detection for
// an ecall sitting in ID.
module ecall_x17_hazard
    import ecall_halt_controller_pkg::*;
#(
    parameter logic [4:0] ECALL_REG = ECALL_REG_DEFAULT
) (
    input  logic       id_is_ecall,
    input  logic [4:0] id_ex_rd,
    input  logic       id_ex_reg_write,
    input  logic       id_ex_mem_read,
    input  logic [4:0] ex_mem_rd,
    input  logic       ex_mem_reg_write,
    input  logic       ex_mem_mem_read,
    input  logic [4:0] mem_wb_rd,
    input  logic       mem_wb_reg_write,
    output logic [1:0] x17_fwd_sel,
    output logic       hazard
);

    logic id_ex_hit;
    logic ex_mem_alu_hit;
    logic ex_mem_load_hit;
    logic mem_wb_hit;
    logic unused_id_ex_mem_read;

    assign id_ex_hit       = id_ex_reg_write && rd_hits(id_ex_rd, ECALL_REG);
    assign ex_mem_alu_hit  = ex_mem_reg_write && !ex_mem_mem_read && rd_hits(ex_mem_rd, ECALL_REG);
    assign ex_mem_load_hit = ex_mem_reg_write && ex_mem_mem_read && rd_hits(ex_mem_rd, ECALL_REG);
    assign mem_wb_hit      = mem_wb_reg_write && rd_hits(mem_wb_rd, ECALL_REG);

    // Any writer in EX stalls regardless of load/ALU, so the EX load flag is not needed
    assign unused_id_ex_mem_read = id_ex_mem_read;

    always_comb begin
        x17_fwd_sel = FWD_RF;
        if (ex_mem_alu_hit) begin
            x17_fwd_sel = FWD_EX_MEM;
        end else if (mem_wb_hit) begin
            x17_fwd_sel = FWD_MEM_WB;
        end
    end

    assign hazard = id_is_ecall && (id_ex_hit || ex_mem_load_hit);

endmodule

// File: rtl/ecall_halt_controller.sv
// Ecall handling: counts service ecalls, and on a halt ecall drains the back
// end of the pipeline before latching a sticky halted flag.
module ecall_halt_controller
    import ecall_halt_controller_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter logic [31:0] HALT_CODE    = HALT_CODE_DEFAULT,
    parameter logic [4:0]  ECALL_REG    = ECALL_REG_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_is_ecall,
    input  logic [4:0]  id_ex_rd,
    input  logic        id_ex_reg_write,
    input  logic        id_ex_mem_read,
    input  logic [4:0]  ex_mem_rd,
    input  logic        ex_mem_reg_write,
    input  logic        ex_mem_mem_read,
    input  logic [4:0]  mem_wb_rd,
    input  logic        mem_wb_reg_write,
    input  logic [31:0] x17_value,
    output logic [1:0]  x17_fwd_sel,
    output logic        stall,
    output logic        flush_if_id,
    output logic        is_halted,
    output logic [31:0] ecall_count,
    output state_t      state_dbg
);

    // A zero-length drain still needs one DRAIN cycle to clear the pipe
    localparam int unsigned DRAIN_EFF = (DRAIN_CYCLES == 0) ? 1 : DRAIN_CYCLES;
    localparam int CNT_W = (DRAIN_EFF > 1) ? $clog2(DRAIN_EFF) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_EFF - 1);

    state_t           state;
    logic [CNT_W-1:0] drain_cnt;
    logic             hazard;

    ecall_x17_hazard #(
        .ECALL_REG(ECALL_REG)
    ) u_x17_hazard (
        .id_is_ecall     (id_is_ecall),
        .id_ex_rd        (id_ex_rd),
        .id_ex_reg_write (id_ex_reg_write),
        .id_ex_mem_read  (id_ex_mem_read),
        .ex_mem_rd       (ex_mem_rd),
        .ex_mem_reg_write(ex_mem_reg_write),
        .ex_mem_mem_read (ex_mem_mem_read),
        .mem_wb_rd       (mem_wb_rd),
        .mem_wb_reg_write(mem_wb_reg_write),
        .x17_fwd_sel     (x17_fwd_sel),
        .hazard          (hazard)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_RUN;
            drain_cnt   <= '0;
            ecall_count <= '0;
            is_halted   <= 1'b0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (id_is_ecall && !hazard) begin
                        if (x17_value == HALT_CODE) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= DRAIN_LOAD;
                        end else begin
                            ecall_count <= ecall_count + 32'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state     <= ST_HALTED;
                        is_halted <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - CNT_W'(1);
                    end
                end
                ST_HALTED: begin
                    state     <= ST_HALTED;
                    is_halted <= 1'b1;
                end
                default: begin
                    state     <= ST_RUN;
                    is_halted <= 1'b0;
                end
            endcase
        end
    end

    // Outside RUN the front end is frozen unconditionally; reset low forces both quiet
    assign stall       = reset && ((state == ST_RUN) ? hazard : 1'b1);
    assign flush_if_id = reset && (state != ST_RUN);
    assign state_dbg   = state;

endmodule

// File: tb/tb_ecall_halt_controller.sv
// Bench for ecall_halt_controller: vector table, directed multi-cycle
// sequences and random traffic against a cycle-stamp reference model.
module tb_ecall_halt_controller;
    import ecall_halt_controller_pkg::*;

    localparam int D = 3;
    localparam int W = 39;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        id_is_ecall = 1'b0;
    logic [4:0]  id_ex_rd = '0;
    logic        id_ex_reg_write = 1'b0;
    logic        id_ex_mem_read = 1'b0;
    logic [4:0]  ex_mem_rd = '0;
    logic        ex_mem_reg_write = 1'b0;
    logic        ex_mem_mem_read = 1'b0;
    logic [4:0]  mem_wb_rd = '0;
    logic        mem_wb_reg_write = 1'b0;
    logic [31:0] x17_value = '0;
    logic [1:0]  x17_fwd_sel;
    logic        stall;
    logic        flush_if_id;
    logic        is_halted;
    logic [31:0] ecall_count;
    state_t      state_dbg;

    ecall_halt_controller #(.DRAIN_CYCLES(D)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_is_ecall     (id_is_ecall),
        .id_ex_rd        (id_ex_rd),
        .id_ex_reg_write (id_ex_reg_write),
        .id_ex_mem_read  (id_ex_mem_read),
        .ex_mem_rd       (ex_mem_rd),
        .ex_mem_reg_write(ex_mem_reg_write),
        .ex_mem_mem_read (ex_mem_mem_read),
        .mem_wb_rd       (mem_wb_rd),
        .mem_wb_reg_write(mem_wb_reg_write),
        .x17_value       (x17_value),
        .x17_fwd_sel     (x17_fwd_sel),
        .stall           (stall),
        .flush_if_id     (flush_if_id),
        .is_halted       (is_halted),
        .ecall_count     (ecall_count),
        .state_dbg       (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the halt is remembered as the edge number that accepted it
    int          m_edge;
    int          m_accept;
    logic [31:0] m_count;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_fwd();
        if (ex_mem_reg_write && !ex_mem_mem_read && ex_mem_rd == 5'd17) return 2'd1;
        if (mem_wb_reg_write && mem_wb_rd == 5'd17) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic model_hazard();
        return id_is_ecall && ((id_ex_reg_write && id_ex_rd == 5'd17) ||
               (ex_mem_mem_read && ex_mem_reg_write && ex_mem_rd == 5'd17));
    endfunction

    function automatic logic [W-1:0] model_expect();
        logic   busy;
        logic   halted;
        state_t st;
        busy   = (m_accept >= 0);
        halted = busy && (m_edge >= m_accept + D);
        st     = halted ? ST_HALTED : (busy ? ST_DRAIN : ST_RUN);
        return {st, (busy ? 1'b1 : model_hazard()), busy, halted, model_fwd(), m_count};
    endfunction

    task automatic model_reset();
        m_edge   = 0;
        m_accept = -1;
        m_count  = '0;
    endtask

    task automatic model_update();
        m_edge++;
        if (m_accept < 0 && id_is_ecall && !model_hazard()) begin
            if (x17_value == 32'd10) m_accept = m_edge;
            else m_count = m_count + 32'd1;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        id_is_ecall = 0; id_ex_rd = 0; id_ex_reg_write = 0; id_ex_mem_read = 0;
        ex_mem_rd = 0; ex_mem_reg_write = 0; ex_mem_mem_read = 0;
        mem_wb_rd = 0; mem_wb_reg_write = 0; x17_value = 32'd1;
    endtask

    function automatic logic [4:0] pick_rd();
        int r;
        r = $urandom_range(0, 3);
        if (r == 0) return 5'd17;
        if (r == 1) return 5'd0;
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic drive_random();
        id_is_ecall      = 1'($urandom_range(0, 1));
        id_ex_rd         = pick_rd();
        id_ex_reg_write  = 1'($urandom_range(0, 1));
        id_ex_mem_read   = 1'($urandom_range(0, 1));
        ex_mem_rd        = pick_rd();
        ex_mem_reg_write = 1'($urandom_range(0, 1));
        ex_mem_mem_read  = 1'($urandom_range(0, 1));
        mem_wb_rd        = pick_rd();
        mem_wb_reg_write = 1'($urandom_range(0, 1));
        x17_value        = ($urandom_range(0, 29) == 0) ? 32'd10 : $urandom;
    endtask

    // Inputs are driven at negedge; outputs compared 1ns later, model advanced at posedge
    task automatic cycle_check(input string name);
        logic [W-1:0] e;
        #1;
        exp_q.push_back(model_expect());
        e = exp_q.pop_front();
        check({name, ".state"}, 32'(state_dbg), 32'(e[38:37]));
        check({name, ".stall"}, 32'(stall), 32'(e[36]));
        check({name, ".flush"}, 32'(flush_if_id), 32'(e[35]));
        check({name, ".halted"}, 32'(is_halted), 32'(e[34]));
        check({name, ".fwd"}, 32'(x17_fwd_sel), 32'(e[33:32]));
        check({name, ".count"}, ecall_count, e[31:0]);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        reset = 1'b0;
        model_reset();
        #1;
        check("rst.state", 32'(state_dbg), 32'(ST_RUN));
        check("rst.halted", 32'(is_halted), 0);
        check("rst.count", ecall_count, 0);
        check("rst.stall", 32'(stall), 0);
        check("rst.flush", 32'(flush_if_id), 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       ecall;
        logic [4:0] ie_rd;
        logic       ie_rw;
        logic       ie_mr;
        logic [4:0] em_rd;
        logic       em_rw;
        logic       em_mr;
        logic [4:0] mw_rd;
        logic       mw_rw;
        logic [1:0] fwd;
        logic       stall;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 2'd0, 1'b0};
        vecs[1]  = '{1'b1, 5'd17, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 2'd0, 1'b1};
        vecs[2]  = '{1'b1, 5'd17, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 2'd0, 1'b0};
        vecs[3]  = '{1'b1, 5'd0,  1'b0, 1'b0, 5'd17, 1'b1, 1'b1, 5'd0,  1'b0, 2'd0, 1'b1};
        vecs[4]  = '{1'b1, 5'd0,  1'b0, 1'b0, 5'd17, 1'b1, 1'b0, 5'd0,  1'b0, 2'd1, 1'b0};
        vecs[5]  = '{1'b0, 5'd17, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 2'd0, 1'b0};
        vecs[6]  = '{1'b0, 5'd0,  1'b0, 1'b0, 5'd17, 1'b1, 1'b0, 5'd17, 1'b1, 2'd1, 1'b0};
        vecs[7]  = '{1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 5'd0,  1'b1, 2'd0, 1'b0};
        vecs[8]  = '{1'b0, 5'd0,  1'b0, 1'b0, 5'd3,  1'b1, 1'b0, 5'd17, 1'b1, 2'd2, 1'b0};
        vecs[9]  = '{1'b1, 5'd0,  1'b0, 1'b0, 5'd17, 1'b1, 1'b1, 5'd17, 1'b1, 2'd2, 1'b1};
        vecs[10] = '{1'b0, 5'd0,  1'b0, 1'b0, 5'd16, 1'b1, 1'b0, 5'd0,  1'b0, 2'd0, 1'b0};
        vecs[11] = '{1'b1, 5'd0,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 2'd0, 1'b0};
        vecs[12] = '{1'b1, 5'd17, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 5'd17, 1'b0, 2'd0, 1'b1};
    end

    // ---------------- test sequence ----------------
    initial begin
        drive_idle();
        do_reset();

        for (int i = 0; i < 13; i++) begin
            id_is_ecall = vecs[i].ecall;
            id_ex_rd = vecs[i].ie_rd; id_ex_reg_write = vecs[i].ie_rw; id_ex_mem_read = vecs[i].ie_mr;
            ex_mem_rd = vecs[i].em_rd; ex_mem_reg_write = vecs[i].em_rw; ex_mem_mem_read = vecs[i].em_mr;
            mem_wb_rd = vecs[i].mw_rd; mem_wb_reg_write = vecs[i].mw_rw;
            x17_value = 32'd1;
            #1;
            check($sformatf("vec%0d.fwd", i), 32'(x17_fwd_sel), 32'(vecs[i].fwd));
            check($sformatf("vec%0d.stall", i), 32'(stall), 32'(vecs[i].stall));
            cycle_check($sformatf("vec%0d", i));
        end

        // ALU result in EX blocks the ecall, then forwards from EX/MEM
        do_reset();
        id_is_ecall = 1; id_ex_rd = 17; id_ex_reg_write = 1;
        cycle_check("alu_hz.c0");
        drive_idle();
        id_is_ecall = 1; ex_mem_rd = 17; ex_mem_reg_write = 1;
        #1;
        check("alu_hz.c1.stall", 32'(stall), 0);
        check("alu_hz.c1.fwd", 32'(x17_fwd_sel), 1);
        cycle_check("alu_hz.c1");

        // Load in MEM blocks the ecall, then forwards from MEM/WB
        drive_idle();
        id_is_ecall = 1; ex_mem_rd = 17; ex_mem_reg_write = 1; ex_mem_mem_read = 1;
        #1;
        check("ld_hz.c0.stall", 32'(stall), 1);
        cycle_check("ld_hz.c0");
        drive_idle();
        id_is_ecall = 1; mem_wb_rd = 17; mem_wb_reg_write = 1;
        #1;
        check("ld_hz.c1.stall", 32'(stall), 0);
        check("ld_hz.c1.fwd", 32'(x17_fwd_sel), 2);
        cycle_check("ld_hz.c1");

        // Five service ecalls
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_idle();
            id_is_ecall = 1; x17_value = 32'd1;
            cycle_check("svc");
        end
        drive_idle();
        #1;
        check("svc.count5", ecall_count, 32'd5);
        check("svc.halted", 32'(is_halted), 0);

        // Halt ecall: drain then sticky halt
        drive_idle();
        id_is_ecall = 1; x17_value = 32'd10;
        cycle_check("halt.req");
        drive_idle();
        for (int i = 0; i < D; i++) begin
            #1;
            check("halt.drain.stall", 32'(stall), 1);
            check("halt.drain.flush", 32'(flush_if_id), 1);
            check("halt.drain.halted", 32'(is_halted), 0);
            cycle_check("halt.drain");
        end
        #1;
        check("halt.rise", 32'(is_halted), 1);
        for (int i = 0; i < 24; i++) begin
            drive_random();
            cycle_check("halt.hold");
        end

        // Reset in the second drain cycle aborts the halt
        do_reset();
        drive_idle();
        id_is_ecall = 1; x17_value = 32'd1;
        cycle_check("abort.svc");
        drive_idle();
        id_is_ecall = 1; x17_value = 32'd10;
        cycle_check("abort.req");
        drive_idle();
        cycle_check("abort.drain1");
        reset = 1'b0;
        model_reset();
        #1;
        check("abort.state", 32'(state_dbg), 32'(ST_RUN));
        check("abort.halted", 32'(is_halted), 0);
        check("abort.count", ecall_count, 0);
        check("abort.stall", 32'(stall), 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) cycle_check("abort.after");
        #1;
        check("abort.no_halt", 32'(is_halted), 0);

        // Random traffic, several reset epochs
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < 200; i++) begin
                drive_random();
                cycle_check("rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ecall_halt_controller.md
ECALL_HALT_CONTROLLER -- requirements
Module: ecall_halt_controller

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3: cycles to drain ID/EX, EX/MEM and MEM/WB after a halt ecall.
REQ-002 SHALL have parameter HALT_CODE, default 32'd10: x17 value that requests a halt.
REQ-003 SHALL have parameter ECALL_REG, default 5'd17: register read by ecall.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 id_is_ecall  in  1  valid ecall instruction in ID.
REQ-007 id_ex_rd / id_ex_reg_write / id_ex_mem_read  in  5/1/1  destination info of the instruction in EX.
REQ-008 ex_mem_rd / ex_mem_reg_write / ex_mem_mem_read  in  5/1/1  destination info of the instruction in MEM.
REQ-009 mem_wb_rd / mem_wb_reg_write  in  5/1  destination info of the instruction in WB.
REQ-010 x17_value  in  32  x17 operand after muxing by x17_fwd_sel.
REQ-011 x17_fwd_sel  out  2  0 = register file, 1 = EX/MEM ALU result, 2 = MEM/WB write data.
REQ-012 stall  out  1  hold PC and IF/ID, insert bubble into ID/EX.
REQ-013 flush_if_id  out  1  squash IF/ID contents.
REQ-014 is_halted  out  1  program finished; sticky.
REQ-015 ecall_count  out  32  number of non-halt ecalls retired from ID.

Function
REQ-016 SHALL implement states RUN, DRAIN and HALTED; reset state RUN.
REQ-017 x17_fwd_sel SHALL be 1 when ex_mem_reg_write && ex_mem_rd==ECALL_REG && !ex_mem_mem_read; else 2 when mem_wb_reg_write && mem_wb_rd==ECALL_REG; else 0. EX/MEM has priority over MEM/WB.
REQ-018 x17 hazard SHALL be id_is_ecall && ((id_ex_reg_write && id_ex_rd==ECALL_REG) || (ex_mem_mem_read && ex_mem_reg_write && ex_mem_rd==ECALL_REG)).
REQ-019 In RUN, stall SHALL equal the x17 hazard combinationally; the ecall remains in ID until the hazard clears.
REQ-020 In RUN with id_is_ecall, no hazard and x17_value==HALT_CODE, the FSM SHALL enter DRAIN next edge and load the drain counter with DRAIN_CYCLES-1.
REQ-021 In RUN with id_is_ecall, no hazard and x17_value!=HALT_CODE, ecall_count SHALL increment by 1 (wrapping modulo 2^32) and the FSM SHALL stay in RUN.
REQ-022 In DRAIN, stall and flush_if_id SHALL be 1; the counter SHALL decrement each cycle; on the cycle the counter equals 0, the next state SHALL be HALTED.
REQ-023 Halt ecall to is_halted rising SHALL take exactly DRAIN_CYCLES+1 edges; DRAIN_CYCLES==0 SHALL be treated as 1.
REQ-024 In HALTED, is_halted, stall and flush_if_id SHALL be 1 and the FSM SHALL remain there until reset; id_is_ecall is ignored.
REQ-025 In DRAIN and HALTED, x17_fwd_sel SHALL still follow REQ-017 and ecall_count SHALL not change.
REQ-026 is_halted SHALL be a registered output (state==HALTED), free of combinational input paths.
REQ-027 Register-0 destinations SHALL never match (ECALL_REG assumed nonzero; rd==0 never forwards).

Reset
REQ-028 Asserting reset (low) SHALL asynchronously force state RUN, drain counter 0, ecall_count 0, is_halted 0.
REQ-029 While reset is low, stall and flush_if_id SHALL be 0 and x17_fwd_sel SHALL follow REQ-017.
REQ-030 Reset asserted mid-DRAIN SHALL abort the drain; after release, is_halted SHALL not assert without a new halt ecall.

Structure
REQ-031 State encoding (RUN/DRAIN/HALTED), ECALL_REG and HALT_CODE defaults and the x17_fwd_sel encodings SHALL live in the shared CPU package.
REQ-032 x17 forwarding-select and hazard logic SHALL be a sub-module ecall_x17_hazard; FSM, drain counter and ecall_count in the top.

Verification
REQ-033 id_is_ecall=1, id_ex_rd=17, id_ex_reg_write=1 -> stall=1 that cycle; next cycle rd moves to EX/MEM (non-load), stall=0, x17_fwd_sel=1.
REQ-034 id_is_ecall=1, ex_mem_rd=17, ex_mem_mem_read=1, ex_mem_reg_write=1 -> stall=1; after it moves to MEM/WB -> stall=0, x17_fwd_sel=2.
REQ-035 Ecall, no hazard, x17_value=10, DRAIN_CYCLES=3 -> stall/flush_if_id high next 3 cycles, is_halted=1 on 4th edge and stays 1 for 20+ cycles.
REQ-036 Five ecalls with x17_value=1 -> ecall_count=5, is_halted=0, stall=0 throughout.
REQ-037 Reset pulsed low during the 2nd DRAIN cycle -> state RUN, is_halted=0, ecall_count=0 immediately (before next edge).
REQ-038 ex_mem_rd=17 and mem_wb_rd=17 both writing, no load -> x17_fwd_sel=1; rd=0 on both -> x17_fwd_sel=0.
